p09_spi_rx: RTL and testbench
=============================

// Module: p09_spi_rx
// PURPOSE
//   SPI slave receiver (mode 0, MSB first) for the breakout display/control link.
//   Oversamples SCLK/MOSI/CS_N on the system clock and deserialises WORD_W-bit words.
//   Emits start on frame open and word/word_en per complete word.
//   Drives the SPI command/line controller directly downstream.
// PARAMETERS
//   WORD_W       16  bits per SPI word (>= 2)
//   SYNC_STAGES  2   flops in each input synchroniser chain (>= 2)
// PORTS
//   clk         in   1       system clock; must be >= 4x SCLK frequency
//   rst         in   1       synchronous, active-high reset
//   spi_sclk    in   1       SPI clock, async to clk, idle low
//   spi_mosi    in   1       SPI data, async; sampled on SCLK rising edge
//   spi_cs_n    in   1       SPI chip select, async, active low
//   start       out  1       1-cycle pulse: frame opened (CS_N fall detected)
//   word        out  WORD_W  last complete word; held until the next word completes
//   word_en     out  1       1-cycle pulse: word updated this cycle
//   frame_err   out  1       1-cycle pulse: CS_N rose with a partial word pending
//   busy        out  1       high while in RECV
// BEHAVIOUR
//   Reset values: start=0, word=0, word_en=0, frame_err=0, busy=0, state=WAIT_IDLE, bit_cnt=0.
//   Synchronisers: SYNC_STAGES-flop chains on sclk, mosi and cs_n (s_sclk, s_mosi, s_cs_n).
//     One extra register per signal (p_sclk, p_cs_n) for edge detection.
//     sclk_rise = s_sclk & ~p_sclk.
//     cs_fall = ~s_cs_n & p_cs_n.
//     cs_rise = s_cs_n & ~p_cs_n.
//     Shift uses s_mosi, which is aligned with s_sclk.
//   FSM:
//     WAIT_IDLE: entered on reset. Moves to IDLE once s_cs_n==1.
//       A frame already in flight at reset release is ignored entirely.
//     IDLE: on cs_fall -> RECV; start=1 that cycle; bit_cnt=0; shift register cleared.
//     RECV: on each sclk_rise, shreg <= {shreg[WORD_W-2:0], s_mosi}; bit_cnt++.
//       When bit_cnt==WORD_W-1 at a sclk_rise:
//         - shreg completes;
//         - the next cycle sets word <= completed shreg and word_en=1;
//         - bit_cnt wraps to 0 and reception continues (back-to-back words, CS held low).
//       On cs_rise -> IDLE:
//         - if bit_cnt!=0, frame_err=1 that cycle and the partial word is discarded
//           (word unchanged, no word_en);
//         - if bit_cnt==0, no pulse.
//       cs_rise has priority over a sclk_rise detected in the same cycle; that bit is dropped.
//   Latency: word_en is asserted exactly SYNC_STAGES+2 clk cycles after the clk edge
//     that first samples the final SCLK rising edge high.
//     start follows the first low sample of CS_N by SYNC_STAGES+1 cycles.
//   start and word_en are never high in the same cycle; the minimum spacing is WORD_W SCLK periods.
//   word_en and frame_err are mutually exclusive.
//   SCLK edges seen in IDLE/WAIT_IDLE are ignored.
//   Reset asserted mid-frame: all outputs go to reset values next cycle; FSM returns to WAIT_IDLE.
//   busy = (state==RECV).
// TESTING
//   1. Reset; CS low, send 0x0001 at SCLK=clk/8, CS high.
//      -> start pulse once, one word_en with word=0x0001, no frame_err.
//   2. One CS frame with 0xABCD then 0x1234 back-to-back.
//      -> two word_en pulses, word=0xABCD then 0x1234; start pulses only once.
//   3. CS low, 9 bits sent, CS high.
//      -> frame_err pulse, no word_en, word keeps its prior value; busy drops.
//   4. Hold CS low and toggle SCLK across reset release, then send a new frame with 0x00F0.
//      -> nothing emitted until CS goes high; new frame yields word=0x00F0.
//   5. Assert rst after bit 7 of a frame.
//      -> next cycle word=0, busy=0; the rest of that frame produces no word_en.
//   6. Random async phase between SCLK and clk at ratio 4:1, 1000 words.
//      -> every word received matches the word transmitted.

Source files
------------

// File: rtl/p09_spi_rx.sv
// SPI slave receiver, mode 0, MSB first.
// SCLK, MOSI and CS_N are oversampled on the system clock.
// The receiver deserialises WORD_W-bit words and holds the last complete word.
// start pulses when a frame opens.
// word_en pulses for each completed word.
// frame_err pulses when CS_N closes the frame with a partial word pending.
module p09_spi_rx #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              start,
  output logic [WORD_W-1:0] word,
  output logic              word_en,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;

  logic sSclk;
  logic sMosi;
  logic sCsN;

  logic pSclk_q;
  logic pCsN_q;
  logic sclkRise_q;
  logic csFall_q;
  logic csRise_q;
  logic mosiDly_q;

  state_t            state_q;
  logic [CNT_W-1:0]  bitCnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic              pend_q;
  logic              start_q;
  logic [WORD_W-1:0] word_q;
  logic              wordEn_q;
  logic              frameErr_q;

  assign sSclk = sclkSync_q[SYNC_STAGES-1];
  assign sMosi = mosiSync_q[SYNC_STAGES-1];
  assign sCsN  = csSync_q[SYNC_STAGES-1];

  // Synchroniser chains.
  // CS_N resets to "selected", so a line that is really low at reset release
  // is never mistaken for an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      csSync_q   <= '0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi_cs_n};
    end
  end

  // Edge detection.
  // The edge pulses are registered, and MOSI is delayed alongside them,
  // so that each shifted bit is the one captured with its SCLK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pSclk_q    <= 1'b0;
      pCsN_q     <= 1'b0;
      sclkRise_q <= 1'b0;
      csFall_q   <= 1'b0;
      csRise_q   <= 1'b0;
      mosiDly_q  <= 1'b0;
    end else begin
      pSclk_q    <= sSclk;
      pCsN_q     <= sCsN;
      sclkRise_q <= sSclk & ~pSclk_q;
      csFall_q   <= ~sCsN & pCsN_q;
      csRise_q   <= sCsN & ~pCsN_q;
      mosiDly_q  <= sMosi;
    end
  end

  // Frame FSM, shift register and registered output pulses.
  // A completed word is published one cycle after its last bit is shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_IDLE;
      bitCnt_q   <= '0;
      shreg_q    <= '0;
      pend_q     <= 1'b0;
      start_q    <= 1'b0;
      word_q     <= '0;
      wordEn_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      wordEn_q   <= 1'b0;
      frameErr_q <= 1'b0;
      if (pend_q) begin
        word_q   <= shreg_q;
        wordEn_q <= 1'b1;
        pend_q   <= 1'b0;
      end
      case (state_q)
        WAIT_IDLE: begin
          if (pCsN_q) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (csFall_q) begin
            state_q  <= RECV;
            start_q  <= 1'b1;
            bitCnt_q <= '0;
            shreg_q  <= '0;
          end
        end
        RECV: begin
          if (csRise_q) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            if (bitCnt_q != '0) begin
              frameErr_q <= 1'b1;
            end
          end else if (sclkRise_q) begin
            shreg_q <= {shreg_q[WORD_W-2:0], mosiDly_q};
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_q <= '0;
              pend_q   <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

  assign start     = start_q;
  assign word      = word_q;
  assign word_en   = wordEn_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_p09_spi_rx.sv
// Self-checking bench for p09_spi_rx.
// A bus-level SPI master drives the DUT, and a monitor collects the output events.
// Each test compares those events against the words the master actually sent.
`timescale 1ns/1ps
module tb_p09_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        start;
  logic [15:0] word;
  logic        word_en;
  logic        frame_err;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [15:0] gotQ[$];
  int startCnt = 0;
  int errCnt = 0;
  int clashCnt = 0;

  p09_spi_rx #(.WORD_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .start(start),
    .word(word),
    .word_en(word_en),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (word_en) gotQ.push_back(word);
    if (start) startCnt++;
    if (frame_err) errCnt++;
    if ((word_en && start) || (word_en && frame_err)) clashCnt++;
  end

  // Mode 0 master: MOSI changes while SCLK is low, and the bits go out MSB first.
  task automatic shiftBits(input logic [15:0] data, input int nbits, input real halfNs);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = data[i];
      #(halfNs) spi_sclk = 1'b1;
      #(halfNs) spi_sclk = 1'b0;
    end
  endtask

  task automatic openFrame(input real halfNs);
    spi_cs_n = 1'b0;
    #(halfNs);
  endtask

  task automatic closeFrame(input real halfNs);
    #(halfNs) spi_cs_n = 1'b1;
    #(halfNs * 4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b want 0", start); end
    total++; if (word !== 16'h0000) begin bad++; $display("[TB] FAIL reset_word: got %h want 0000", word); end
    total++; if (word_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_word_en: got %b want 0", word_en); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // A single word at clk/8, with the start and word_en latencies checked.
  task automatic test_single();
    int w0, s0, e0;
    w0 = gotQ.size(); s0 = startCnt; e0 = errCnt;
    @(posedge clk); #2;
    spi_cs_n = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL start_early: got %b want 0", start); end
    @(posedge clk); #1;
    total++; if (start !== 1'b1) begin bad++; $display("[TB] FAIL start_latency: got %b want 1", start); end
    @(posedge clk); #2;
    shiftBits(16'h0000, 15, 40.0);
    spi_mosi = 1'b1;
    #40 spi_sclk = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    total++; if (word_en !== 1'b0) begin bad++; $display("[TB] FAIL word_en_early: got %b want 0", word_en); end
    @(posedge clk); #1;
    total++; if (word_en !== 1'b1 || word !== 16'h0001) begin bad++; $display("[TB] FAIL word_en_latency: got en=%b word=%h want en=1 word=0001", word_en, word); end
    #20 spi_sclk = 1'b0;
    closeFrame(40.0);
    total++; if (gotQ.size() - w0 != 1) begin bad++; $display("[TB] FAIL single_count: got %0d want 1", gotQ.size() - w0); end
    else begin
      total++; if (gotQ[w0] !== 16'h0001) begin bad++; $display("[TB] FAIL single_word: got %h want 0001", gotQ[w0]); end
    end
    total++; if (startCnt - s0 != 1) begin bad++; $display("[TB] FAIL single_start: got %0d want 1", startCnt - s0); end
    total++; if (errCnt - e0 != 0) begin bad++; $display("[TB] FAIL single_err: got %0d want 0", errCnt - e0); end
  endtask

  task automatic test_back_to_back();
    int w0, s0;
    w0 = gotQ.size(); s0 = startCnt;
    @(posedge clk); #2;
    openFrame(40.0);
    shiftBits(16'hABCD, 16, 40.0);
    shiftBits(16'h1234, 16, 40.0);
    closeFrame(40.0);
    total++; if (gotQ.size() - w0 != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 2", gotQ.size() - w0); end
    else begin
      total++; if (gotQ[w0] !== 16'hABCD) begin bad++; $display("[TB] FAIL b2b_first: got %h want abcd", gotQ[w0]); end
      total++; if (gotQ[w0+1] !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_second: got %h want 1234", gotQ[w0+1]); end
    end
    total++; if (startCnt - s0 != 1) begin bad++; $display("[TB] FAIL b2b_start: got %0d want 1", startCnt - s0); end
  endtask

  task automatic test_partial(input logic [15:0] lastWord);
    int w0, e0;
    w0 = gotQ.size(); e0 = errCnt;
    @(posedge clk); #2;
    openFrame(40.0);
    shiftBits(16'($urandom), 9, 40.0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL partial_busy_high: got %b want 1", busy); end
    closeFrame(40.0);
    total++; if (errCnt - e0 != 1) begin bad++; $display("[TB] FAIL partial_err: got %0d want 1", errCnt - e0); end
    total++; if (gotQ.size() - w0 != 0) begin bad++; $display("[TB] FAIL partial_word_en: got %0d want 0", gotQ.size() - w0); end
    total++; if (word !== lastWord) begin bad++; $display("[TB] FAIL partial_hold: got %h want %h", word, lastWord); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL partial_busy_low: got %b want 0", busy); end
  endtask

  // Start under reset with CS already low. That frame must be ignored,
  // and the next real frame must still be received.
  task automatic test_reset_release();
    int w0, s0, e0;
    w0 = gotQ.size(); s0 = startCnt; e0 = errCnt;
    @(posedge clk); #2;
    rst = 1'b1;
    spi_cs_n = 1'b0;
    shiftBits(16'($urandom), 8, 40.0);
    rst = 1'b0;
    shiftBits(16'($urandom), 16, 40.0);
    shiftBits(16'($urandom), 4, 40.0);
    total++; if (startCnt - s0 != 0 || gotQ.size() - w0 != 0 || errCnt - e0 != 0) begin bad++; $display("[TB] FAIL inflight_ignored: got start=%0d words=%0d err=%0d want 0/0/0", startCnt - s0, gotQ.size() - w0, errCnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL inflight_busy: got %b want 0", busy); end
    closeFrame(40.0);
    @(posedge clk); #2;
    openFrame(40.0);
    shiftBits(16'h00F0, 16, 40.0);
    closeFrame(40.0);
    total++; if (gotQ.size() - w0 != 1) begin bad++; $display("[TB] FAIL rr_count: got %0d want 1", gotQ.size() - w0); end
    else begin
      total++; if (gotQ[w0] !== 16'h00F0) begin bad++; $display("[TB] FAIL rr_word: got %h want 00f0", gotQ[w0]); end
    end
    total++; if (startCnt - s0 != 1) begin bad++; $display("[TB] FAIL rr_start: got %0d want 1", startCnt - s0); end
  endtask

  task automatic test_mid_reset();
    int w0;
    logic [15:0] d;
    d = 16'($urandom);
    @(posedge clk); #2;
    openFrame(40.0);
    shiftBits(d >> 8, 8, 40.0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (word !== 16'h0000 || busy !== 1'b0 || word_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_outputs: got word=%h busy=%b en=%b want 0000/0/0", word, busy, word_en); end
    rst = 1'b0;
    w0 = gotQ.size();
    shiftBits(d, 8, 40.0);
    closeFrame(40.0);
    total++; if (gotQ.size() - w0 != 0) begin bad++; $display("[TB] FAIL midrst_no_word: got %0d want 0", gotQ.size() - w0); end
  endtask

  // Random words at SCLK = clk/4, with a random sub-cycle phase per frame.
  task automatic test_random();
    logic [15:0] expQ[$];
    logic [15:0] w;
    int w0, s0, e0, frames, sent, n;
    w0 = gotQ.size(); s0 = startCnt; e0 = errCnt;
    frames = 0; sent = 0;
    while (sent < 1000) begin
      n = $urandom_range(1, 40);
      if (sent + n > 1000) n = 1000 - sent;
      @(posedge clk);
      #(real'($urandom_range(100, 9900)) / 1000.0);
      openFrame(20.0);
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        expQ.push_back(w);
        shiftBits(w, 16, 20.0);
      end
      closeFrame(20.0);
      #($urandom_range(0, 50));
      sent += n;
      frames++;
    end
    #200;
    total++; if (gotQ.size() - w0 != 1000) begin bad++; $display("[TB] FAIL rand_count: got %0d want 1000", gotQ.size() - w0); end
    for (int k = 0; k < expQ.size() && (w0 + k) < gotQ.size(); k++) begin
      total++; if (gotQ[w0+k] !== expQ[k]) begin bad++; $display("[TB] FAIL rand_word[%0d]: got %h want %h", k, gotQ[w0+k], expQ[k]); end
    end
    total++; if (startCnt - s0 != frames) begin bad++; $display("[TB] FAIL rand_start: got %0d want %0d", startCnt - s0, frames); end
    total++; if (errCnt - e0 != 0) begin bad++; $display("[TB] FAIL rand_err: got %0d want 0", errCnt - e0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_partial(16'h1234);
    test_reset_release();
    test_mid_reset();
    test_random();
    total++; if (clashCnt != 0) begin bad++; $display("[TB] FAIL pulse_exclusive: got %0d want 0", clashCnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
